// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for idle-high asynchronous inputs.
module uart_sync2 (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receive engine: 8N1 deserializer with oversampled bit timing,
// one-cycle FIFO write strobe and sticky framing/overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       baud_tick,
  input  logic       rx_serial,
  input  logic       rx_fifo_full,
  output logic       rx_fifo_wr_en,
  output logic [7:0] rx_fifo_data,
  output logic       frame_err,
  output logic       overrun_err,
  input  logic       err_clr,
  output logic       rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;

  localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  rx_state_t            state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 rxs;
  logic                 brk;
  logic                 at_end;
  logic                 stop_ok;
  logic                 set_fe;
  logic                 set_oe;

  uart_sync2 u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (rx_serial),
    .q       (rxs)
  );

  assign at_end  = baud_tick && (tick_cnt == LAST);
  assign stop_ok = (state == STOP) && at_end && rxs;
  assign set_fe  = (state == STOP) && at_end && !rxs;
  assign set_oe  = stop_ok && rx_fifo_full;
  assign rx_busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      brk      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // after a break, the line must go high before a new start
          if (rxs) brk <= 1'b0;
          if (!rxs && !brk) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (baud_tick) begin
            if (tick_cnt == MID) begin
              if (rxs) begin
                state <= IDLE;
              end else begin
                state    <= DATA;
                tick_cnt <= '0;
                bit_cnt  <= '0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (baud_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == LAST) begin
              shift   <= {rxs, shift[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) state <= STOP;
            end
          end
        end
        STOP: begin
          if (baud_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == LAST) begin
              state <= IDLE;
              brk   <= !rxs;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_fifo_wr_en <= 1'b0;
      rx_fifo_data  <= '0;
      frame_err     <= 1'b0;
      overrun_err   <= 1'b0;
    end else begin
      rx_fifo_wr_en <= stop_ok && !rx_fifo_full;
      if (stop_ok && !rx_fifo_full) rx_fifo_data <= 8'(shift);
      frame_err   <= set_fe | (frame_err & !err_clr);
      overrun_err <= set_oe | (overrun_err & !err_clr);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of frames plus glitch,
// back-to-back and mid-frame reset sequences.
module tb_uart_rx;

  localparam int BIT = 64;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       baud_tick = 1'b0;
  logic       rx_serial;
  logic       rx_fifo_full;
  logic       rx_fifo_wr_en;
  logic [7:0] rx_fifo_data;
  logic       frame_err;
  logic       overrun_err;
  logic       err_clr;
  logic       rx_busy;

  int total = 0;
  int bad = 0;
  logic [1:0] div = '0;
  logic [7:0] got[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       full;
    logic       clr;
    logic       exp_wr;
    logic       exp_fe;
    logic       exp_oe;
  } vec_t;

  vec_t vecs[6];

  uart_rx dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .baud_tick     (baud_tick),
    .rx_serial     (rx_serial),
    .rx_fifo_full  (rx_fifo_full),
    .rx_fifo_wr_en (rx_fifo_wr_en),
    .rx_fifo_data  (rx_fifo_data),
    .frame_err     (frame_err),
    .overrun_err   (overrun_err),
    .err_clr       (err_clr),
    .rx_busy       (rx_busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    baud_tick = (div == 2'd3);
    div = div + 2'd1;
  end

  always @(negedge clock) begin
    if (reset_n && rx_fifo_wr_en) got.push_back(rx_fifo_data);
  end

  task automatic compare(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx_serial = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive(1'b0, BIT);
    for (int b = 0; b < 8; b++) drive(d[b], BIT);
    drive(stop, BIT);
    rx_serial = 1'b1;
  endtask

  initial begin
    int n0;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h81, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h7E, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    reset_n = 1'b0;
    rx_serial = 1'b1;
    rx_fifo_full = 1'b0;
    err_clr = 1'b0;
    repeat (4) @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    compare("rst_wr", rx_fifo_wr_en, 0);
    compare("rst_data", rx_fifo_data, 0);
    compare("rst_fe", frame_err, 0);
    compare("rst_oe", overrun_err, 0);
    compare("rst_busy", rx_busy, 0);

    n0 = got.size();
    drive(1'b0, 19);
    compare("glitch_busy_hi", rx_busy, 1);
    drive(1'b1, BIT);
    compare("glitch_busy_lo", rx_busy, 0);
    compare("glitch_strobes", got.size() - n0, 0);
    compare("glitch_fe", frame_err, 0);
    compare("glitch_oe", overrun_err, 0);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].clr) begin
        err_clr = 1'b1;
        @(negedge clock);
        err_clr = 1'b0;
        @(negedge clock);
        compare($sformatf("v%0d_clr_fe", i), frame_err, 0);
        compare($sformatf("v%0d_clr_oe", i), overrun_err, 0);
      end
      rx_fifo_full = vecs[i].full;
      n0 = got.size();
      send_frame(vecs[i].data, vecs[i].stop);
      drive(1'b1, 2 * BIT);
      rx_fifo_full = 1'b0;
      compare($sformatf("v%0d_strobes", i), got.size() - n0,
              32'(vecs[i].exp_wr));
      if (vecs[i].exp_wr && got.size() > n0)
        compare($sformatf("v%0d_data", i), got[n0], vecs[i].data);
      compare($sformatf("v%0d_fe", i), frame_err, vecs[i].exp_fe);
      compare($sformatf("v%0d_oe", i), overrun_err, vecs[i].exp_oe);
      compare($sformatf("v%0d_busy", i), rx_busy, 0);
    end

    n0 = got.size();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    drive(1'b1, 2 * BIT);
    compare("b2b_strobes", got.size() - n0, 3);
    if (got.size() >= n0 + 3) begin
      compare("b2b_d0", got[n0], 8'h00);
      compare("b2b_d1", got[n0+1], 8'hFF);
      compare("b2b_d2", got[n0+2], 8'h55);
    end
    compare("b2b_fe", frame_err, 0);

    n0 = got.size();
    drive(1'b0, BIT);
    drive(1'b0, BIT);
    drive(1'b1, BIT);
    drive(1'b0, BIT);
    compare("mid_busy", rx_busy, 1);
    reset_n = 1'b0;
    rx_serial = 1'b1;
    repeat (3) @(negedge clock);
    compare("mid_rst_busy", rx_busy, 0);
    compare("mid_rst_wr", rx_fifo_wr_en, 0);
    compare("mid_rst_data", rx_fifo_data, 0);
    reset_n = 1'b1;
    drive(1'b1, BIT);
    compare("mid_no_strobe", got.size() - n0, 0);
    send_frame(8'h34, 1'b1);
    drive(1'b1, 2 * BIT);
    compare("post_rst_strobes", got.size() - n0, 1);
    if (got.size() > n0) compare("post_rst_data", got[n0], 8'h34);
    compare("post_rst_fe", frame_err, 0);
    compare("post_rst_oe", overrun_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
